// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - FC engine states, saturation bounds and output scaling (build option FC_RELU_EN)
package fc_pkg;

    localparam int FC_DATA_W  = 8;
    localparam int FC_ACC_W   = 32;
    localparam int FC_SAT_MAX = (1 << (FC_DATA_W - 1)) - 1;
    localparam int FC_SAT_MIN = -(1 << (FC_DATA_W - 1));

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        BIAS,
        MAC,
        DRAIN,
        DONE
    } fc_state_e;

    // Arithmetic right shift, optional ReLU clamp, then saturation to the element range.
    function automatic logic [FC_DATA_W-1:0] sat_shift(input logic signed [FC_ACC_W-1:0] acc,
                                                       input logic [4:0] shift);
        logic signed [FC_ACC_W-1:0] s;
        s = acc >>> shift;
`ifdef FC_RELU_EN
        if (s < 0) begin
            s = '0;
        end
`else
        s = s;
`endif
        if (s > FC_SAT_MAX) begin
            return FC_DATA_W'(FC_SAT_MAX);
        end
        if (s < FC_SAT_MIN) begin
            return FC_DATA_W'(FC_SAT_MIN);
        end
        return s[FC_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// rtl/fc_mac_lane.sv - one output-neuron accumulator with bias load, MAC and scaled saturated result
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_bias,
    input  logic                     mac_en,
    input  logic [4:0]               shift,
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] x_val,
    input  logic signed [DATA_W-1:0] w_val,
    output logic [DATA_W-1:0]        y
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           bias_ext;
    logic [ACC_W-1:0]           prod_ext;

    assign prod     = x_val * w_val;
    assign bias_ext = {{(ACC_W - DATA_W){bias[DATA_W-1]}}, bias};
    assign prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};

    // Accumulator: bias is pre-scaled so the final shift leaves it at unit weight; sums wrap at ACC_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (load_bias) begin
            acc <= bias_ext << shift;
        end else if (mac_en) begin
            acc <= acc + prod_ext;
        end
    end

    assign y = DATA_W'(sat_shift(FC_ACC_W'(acc), shift));

endmodule

// File: rtl/fc_stream_mac_engine.sv
// rtl/fc_stream_mac_engine.sv - streamed, lane-multiplexed fully-connected layer (ReLU via FC_RELU_EN)
module fc_stream_mac_engine
    import fc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MAX_IN  = 128,
    parameter int MAX_OUT = 64,
    parameter int LANES   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(MAX_IN):0]    in_size,
    input  logic [$clog2(MAX_OUT):0]   out_size,
    input  logic [4:0]                 shift_amt,
    input  logic                       x_valid,
    output logic                       x_ready,
    input  logic [DATA_W-1:0]          x_data,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [LANES*DATA_W-1:0]    w_data,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [DATA_W-1:0]          y_data,
    output logic                       busy,
    output logic                       done
);

    localparam int IN_W  = $clog2(MAX_IN) + 1;
    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam int AW    = $clog2(MAX_IN);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    fc_state_e state, state_nx;

    logic [IN_W-1:0]   in_sz, idx, in_clamped;
    logic [OUT_W-1:0]  out_sz, base, out_clamped;
    logic [LW-1:0]     lane;
    logic [4:0]        shift_r;
    logic [DATA_W-1:0] xbuf [MAX_IN];
    logic [DATA_W-1:0] lane_y [LANES];
    logic [DATA_W-1:0] x_cur;
    logic [OUT_W:0]    nxt_neuron, nxt_group;
    logic              x_fire, w_fire, y_fire;
    logic              idx_last, lane_last, more_groups, bias_en, mac_en;

    assign x_fire      = x_valid && x_ready;
    assign w_fire      = w_valid && w_ready;
    assign y_fire      = y_valid && y_ready;
    assign idx_last    = (idx == in_sz - IN_W'(1));
    assign nxt_neuron  = {1'b0, base} + (OUT_W + 1)'(lane) + (OUT_W + 1)'(1);
    assign nxt_group   = {1'b0, base} + (OUT_W + 1)'(LANES);
    assign lane_last   = (lane == LW'(LANES - 1)) || (nxt_neuron >= {1'b0, out_sz});
    assign more_groups = nxt_group < {1'b0, out_sz};
    assign bias_en     = (state == BIAS) && w_fire;
    assign mac_en      = (state == MAC) && w_fire;
    assign x_cur       = xbuf[idx[AW-1:0]];

    // Out-of-range sizes are forced into 1..max so the counters always terminate.
    always_comb begin
        in_clamped  = in_size;
        out_clamped = out_size;
        if (in_size == '0) begin
            in_clamped = IN_W'(1);
        end else if (in_size > IN_W'(MAX_IN)) begin
            in_clamped = IN_W'(MAX_IN);
        end
        if (out_size == '0) begin
            out_clamped = OUT_W'(1);
        end else if (out_size > OUT_W'(MAX_OUT)) begin
            out_clamped = OUT_W'(MAX_OUT);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: each phase advances only on its own stream handshakes.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD_X;
            LOAD_X:  if (x_fire && idx_last) state_nx = BIAS;
            BIAS:    if (w_fire) state_nx = MAC;
            MAC:     if (w_fire && idx_last) state_nx = DRAIN;
            DRAIN:   if (y_fire && lane_last) state_nx = more_groups ? BIAS : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Size latch, element index, group base and drain lane pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_sz   <= '0;
            out_sz  <= '0;
            shift_r <= '0;
            idx     <= '0;
            base    <= '0;
            lane    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_sz   <= in_clamped;
                        out_sz  <= out_clamped;
                        shift_r <= shift_amt;
                        idx     <= '0;
                        base    <= '0;
                        lane    <= '0;
                    end
                end
                LOAD_X, MAC: begin
                    if ((state == LOAD_X) ? x_fire : w_fire) begin
                        idx <= idx_last ? '0 : idx + IN_W'(1);
                    end
                end
                DRAIN: begin
                    if (y_fire) begin
                        if (lane_last) begin
                            lane <= '0;
                            base <= nxt_group[OUT_W-1:0];
                        end else begin
                            lane <= lane + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Input vector buffer, reused by every output group.
    always_ff @(posedge clk) begin
        if (x_fire) begin
            xbuf[idx[AW-1:0]] <= x_data;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fc_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load_bias (bias_en),
            .mac_en    (mac_en),
            .shift     (shift_r),
            .bias      (w_data[k*DATA_W +: DATA_W]),
            .x_val     (x_cur),
            .w_val     (w_data[k*DATA_W +: DATA_W]),
            .y         (lane_y[k])
        );
    end

    assign x_ready = (state == LOAD_X);
    assign w_ready = (state == BIAS) || (state == MAC);
    assign y_valid = (state == DRAIN);
    assign y_data  = y_valid ? lane_y[lane] : '0;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_fc_stream_mac_engine.sv
// tb/tb_fc_stream_mac_engine.sv - randomized streaming bench for fc_stream_mac_engine with a reference model
module tb_fc_stream_mac_engine;

    localparam int DATA_W  = 8;
    localparam int MAX_IN  = 128;
    localparam int MAX_OUT = 64;
    localparam int LANES   = 4;
    localparam int BOUND   = 20000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [7:0]              in_size = '0;
    logic [6:0]              out_size = '0;
    logic [4:0]              shift_amt = '0;
    logic                    x_valid = 1'b0;
    logic                    x_ready;
    logic [DATA_W-1:0]       x_data = '0;
    logic                    w_valid = 1'b0;
    logic                    w_ready;
    logic [LANES*DATA_W-1:0] w_data = '0;
    logic                    y_valid;
    logic                    y_ready = 1'b0;
    logic [DATA_W-1:0]       y_data;
    logic                    busy;
    logic                    done;

    int xs [MAX_IN];
    int ws [MAX_OUT+LANES][MAX_IN];
    int bs [MAX_OUT+LANES];
    int got [MAX_OUT];
    int n_cmp = 0;
    int n_bad = 0;
    int total_beats = 0;

    always #5 clk = ~clk;

    fc_stream_mac_engine #(
        .DATA_W (DATA_W), .ACC_W (32), .MAX_IN (MAX_IN), .MAX_OUT (MAX_OUT), .LANES (LANES)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .in_size (in_size), .out_size (out_size),
        .shift_amt (shift_amt), .x_valid (x_valid), .x_ready (x_ready), .x_data (x_data),
        .w_valid (w_valid), .w_ready (w_ready), .w_data (w_data), .y_valid (y_valid),
        .y_ready (y_ready), .y_data (y_data), .busy (busy), .done (done)
    );

    task automatic check(input string tag, input longint obs, input longint exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < MAX_IN; i++) xs[i] = rnd8();
        for (int o = 0; o < MAX_OUT + LANES; o++) begin
            bs[o] = rnd8();
            for (int i = 0; i < MAX_IN; i++) ws[o][i] = rnd8();
        end
    endtask

    // y[o] = sat(((b << sh) + sum x*W) >>> sh), 32-bit wrapping accumulator.
    function automatic int model_y(input int o, input int n_in, input int sh);
        int acc;
        int s;
        acc = bs[o] <<< sh;
        for (int i = 0; i < n_in; i++) acc += xs[i] * ws[o][i];
        s = acc >>> sh;
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    task automatic run_layer(input int in_raw, input int out_raw, input int sh,
                             input int gap, input int abort_wbeat);
        int n_in, n_out, groups, n_w;
        int xi, wi, yi, cyc, dones, done_cyc;
        int exp_y [MAX_OUT];
        logic [LANES*DATA_W-1:0] wq [$];
        logic [LANES*DATA_W-1:0] beat;
        logic stall_prev;
        logic [DATA_W-1:0] held;

        n_in  = (in_raw == 0) ? 1 : (in_raw > MAX_IN) ? MAX_IN : in_raw;
        n_out = (out_raw == 0) ? 1 : (out_raw > MAX_OUT) ? MAX_OUT : out_raw;
        groups = (n_out + LANES - 1) / LANES;
        n_w = groups * (1 + n_in);
        for (int o = 0; o < n_out; o++) exp_y[o] = model_y(o, n_in, sh);
        wq.delete();
        for (int g = 0; g < groups; g++) begin
            for (int k = 0; k < LANES; k++) beat[k*DATA_W +: DATA_W] = DATA_W'(bs[g*LANES+k]);
            wq.push_back(beat);
            for (int i = 0; i < n_in; i++) begin
                for (int k = 0; k < LANES; k++) beat[k*DATA_W +: DATA_W] = DATA_W'(ws[g*LANES+k][i]);
                wq.push_back(beat);
            end
        end

        @(negedge clk);
        in_size = 8'(in_raw);
        out_size = 7'(out_raw);
        shift_amt = 5'(sh);
        start = 1'b1;
        xi = 0; wi = 0; yi = 0; cyc = 0; dones = 0; done_cyc = -1;
        stall_prev = 1'b0;
        held = '0;
        while (cyc < BOUND) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (abort_wbeat >= 0 && wi >= abort_wbeat) begin
                rst = 1'b1;
                x_valid = 1'b0; w_valid = 1'b0; y_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_y_valid", y_valid, 0);
                check("abort_done", done, 0);
                check("abort_w_ready", w_ready, 0);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                end
                return;
            end
            if (stall_prev) begin
                check("y_hold_valid", y_valid, 1);
                check("y_hold_data", y_data, held);
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            x_valid = (xi < n_in) && ($urandom_range(99) >= gap);
            x_data  = (xi < n_in) ? DATA_W'(xs[xi]) : DATA_W'($urandom);
            w_valid = (wi < n_w) && ($urandom_range(99) >= gap);
            w_data  = (wi < n_w) ? wq[wi] : (LANES*DATA_W)'($urandom);
            y_ready = ($urandom_range(99) >= gap);
            if (x_valid && x_ready) xi++;
            if (w_valid && w_ready) wi++;
            if (y_valid && y_ready) begin
                if (yi < n_out) begin
                    check("y_data", $signed(y_data), exp_y[yi]);
                    got[yi] = int'($signed(y_data));
                end else begin
                    check("y_extra_beat", yi, n_out);
                end
                yi++;
            end
            stall_prev = y_valid && !y_ready;
            held = y_data;
        end
        x_valid = 1'b0; w_valid = 1'b0; y_ready = 1'b0;
        check("done_pulses", dones, 1);
        check("y_beats", yi, n_out);
        check("x_beats", xi, n_in);
        check("w_beats", wi, n_w);
        if (gap == 0) check("latency", done_cyc, 1 + n_in + groups * (1 + n_in) + n_out);
        total_beats += xi + wi + yi;
    endtask

    initial begin
        fill_random();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_x_ready", x_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_y_valid", y_valid, 0);
        check("rst_done", done, 0);
        check("rst_y_data", y_data, 0);
        rst = 1'b0;

        // Small hand-worked layer.
        xs[0] = 1; xs[1] = 2; xs[2] = 3;
        ws[0][0] = 1; ws[0][1] = 1; ws[0][2] = 1;
        ws[1][0] = -1; ws[1][1] = 0; ws[1][2] = 2;
        bs[0] = 0; bs[1] = 5;
        run_layer(3, 2, 0, 0, -1);
        check("t1_y0", got[0], 6);
        check("t1_y1", got[1], 10);

        // Saturation at both ends.
        xs[0] = 127; xs[1] = 127; ws[0][0] = 127; ws[0][1] = 127; bs[0] = 0;
        run_layer(2, 1, 0, 0, -1);
        check("t2_sat_hi", got[0], 127);
        ws[0][0] = -127; ws[0][1] = -127;
        run_layer(2, 1, 0, 0, -1);
`ifdef FC_RELU_EN
        check("t2_sat_lo", got[0], 0);
`else
        check("t2_sat_lo", got[0], -128);
`endif

        // Partial tail group.
        fill_random();
        run_layer(3, 5, 0, 20, -1);

        // Full-length input with shift.
        for (int i = 0; i < MAX_IN; i++) begin
            xs[i] = 16; ws[0][i] = 16;
        end
        bs[0] = 1;
        run_layer(MAX_IN, 1, 4, 0, -1);
        check("t6_y0", got[0], 127);

        // Size clamping.
        fill_random();
        run_layer(0, 0, 2, 0, -1);
        run_layer(200, 100, 9, 0, -1);

        // Reset during MAC of the second group, then a clean rerun.
        fill_random();
        run_layer(4, 8, 1, 0, 8);
        run_layer(4, 8, 1, 0, -1);

        // Random layers with back-pressure and gaps on every stream.
        total_beats = 0;
        for (int n = 0; n < 20 && total_beats < 1000; n++) begin
            fill_random();
            run_layer(int'($urandom_range(40, 1)), int'($urandom_range(20, 1)),
                      int'($urandom_range(12)), 30, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
